fp_add_seq: RTL

Multi-cycle IEEE-754 single-precision adder that sits directly downstream of the fixed↔float converter and consumes its float results. It accepts two operands over a valid/ready handshake and aligns and normalizes one bit per cycle, so latency depends on the data. It returns a packed single-precision sum under a second valid/ready handshake. Rounding is truncation (round-toward-zero), and denormals are flushed to zero, matching the converter's supported range.

---
 rtl/fp_pkg.sv | 30 +++
 rtl/fp_unpack.sv | 18 +
 rtl/fp_add_seq.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared single-precision field widths, bias, FSM states and special encodings
// for the sequential float adder.
package fp_pkg;

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned MAN_W  = 23;
    localparam int unsigned MANT_W = MAN_W + 1;
    localparam int unsigned FP_W   = 1 + EXP_W + MAN_W;
    localparam int unsigned BIAS   = 127;

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        ALIGN,
        ADD,
        NORM,
        DONE
    } state_e;

    localparam logic [FP_W-1:0] FP_POS_ZERO = 32'h0000_0000;
    localparam logic [FP_W-1:0] FP_POS_INF  = 32'h7F80_0000;
    localparam logic [FP_W-1:0] FP_NEG_INF  = 32'hFF80_0000;

    function automatic logic [FP_W-1:0] fp_pack(input logic s,
                                                input logic [EXP_W-1:0] e,
                                                input logic [MAN_W-1:0] m);
        return {s, e, m};
    endfunction

endpackage

// File: rtl/fp_unpack.sv
// Splits one single-precision word into sign, exponent and 24-bit mantissa;
// a zero exponent (zero or denormal) is flushed to an all-zero operand.
module fp_unpack
    import fp_pkg::*;
(
    input  logic [FP_W-1:0]   op_i,
    output logic              sign_o,
    output logic [EXP_W-1:0]  exp_o,
    output logic [MANT_W-1:0] mant_o,
    output logic              is_zero_o
);

    assign is_zero_o = (op_i[FP_W-2 -: EXP_W] == '0);
    assign sign_o    = op_i[FP_W-1];
    assign exp_o     = is_zero_o ? '0 : op_i[FP_W-2 -: EXP_W];
    assign mant_o    = is_zero_o ? '0 : {1'b1, op_i[MAN_W-1:0]};

endmodule

// File: rtl/fp_add_seq.sv
// Multi-cycle single-precision adder: bit-serial alignment and normalization,
// truncating rounding, denormals flushed to zero, exponent saturation to inf.
module fp_add_seq #(
    parameter int unsigned BIAS     = 127,
    parameter int unsigned MAXSHIFT = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result
);
    import fp_pkg::*;

    // All-ones biased exponent marks the infinity encoding.
    localparam int unsigned EXP_MAX = 2 * BIAS + 1;

    state_e              state_q;
    logic [FP_W-1:0]     a_q, b_q;
    logic                sx_q, sy_q;
    logic [EXP_W:0]      ex_q;
    logic [MANT_W:0]     mx_q;
    logic [MANT_W-1:0]   my_q;
    logic [EXP_W-1:0]    d_q;
    logic [FP_W-1:0]     result_q;
    logic                out_valid_q;
    logic                in_ready_q;

    logic                sa, sb, za, zb;
    logic [EXP_W-1:0]    ea, eb;
    logic [MANT_W-1:0]   ma, mb;
    logic                a_is_x_c;
    logic [MANT_W:0]     sum_c;

    fp_unpack u_unpack_a (
        .op_i      (a_q),
        .sign_o    (sa),
        .exp_o     (ea),
        .mant_o    (ma),
        .is_zero_o (za)
    );

    fp_unpack u_unpack_b (
        .op_i      (b_q),
        .sign_o    (sb),
        .exp_o     (eb),
        .mant_o    (mb),
        .is_zero_o (zb)
    );

    // X is the operand with larger magnitude so the subtraction never goes negative.
    assign a_is_x_c = zb | (!za & ((ea > eb) | ((ea == eb) & (ma >= mb))));

    assign sum_c = (sx_q == sy_q) ? ({1'b0, mx_q[MANT_W-1:0]} + {1'b0, my_q})
                                  : ({1'b0, mx_q[MANT_W-1:0]} - {1'b0, my_q});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sx_q        <= 1'b0;
            sy_q        <= 1'b0;
            ex_q        <= '0;
            mx_q        <= '0;
            my_q        <= '0;
            d_q         <= '0;
            result_q    <= FP_POS_ZERO;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        in_ready_q <= 1'b0;
                        state_q    <= UNPACK;
                    end
                end
                UNPACK: begin
                    if (a_is_x_c) begin
                        sx_q <= sa;
                        ex_q <= {1'b0, ea};
                        mx_q <= {1'b0, ma};
                        sy_q <= sb;
                        my_q <= mb;
                        d_q  <= ea - eb;
                    end else begin
                        sx_q <= sb;
                        ex_q <= {1'b0, eb};
                        mx_q <= {1'b0, mb};
                        sy_q <= sa;
                        my_q <= ma;
                        d_q  <= eb - ea;
                    end
                    state_q <= ALIGN;
                end
                ALIGN: begin
                    // Large gaps drop the smaller operand at once instead of shifting it out.
                    if (d_q >= EXP_W'(MAXSHIFT)) begin
                        my_q    <= '0;
                        d_q     <= '0;
                        state_q <= ADD;
                    end else if (d_q != '0) begin
                        my_q <= my_q >> 1;
                        d_q  <= d_q - EXP_W'(1);
                    end else begin
                        state_q <= ADD;
                    end
                end
                ADD: begin
                    mx_q    <= sum_c;
                    state_q <= NORM;
                end
                NORM: begin
                    if (mx_q[MANT_W]) begin
                        mx_q <= mx_q >> 1;
                        ex_q <= ex_q + (EXP_W+1)'(1);
                    end else if (mx_q == '0) begin
                        result_q    <= FP_POS_ZERO;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else if (ex_q == '0) begin
                        result_q    <= {sx_q, (FP_W-1)'(0)};
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else if (!mx_q[MANT_W-1]) begin
                        mx_q <= mx_q << 1;
                        ex_q <= ex_q - (EXP_W+1)'(1);
                    end else begin
                        if (ex_q >= (EXP_W+1)'(EXP_MAX)) begin
                            result_q <= sx_q ? FP_NEG_INF : FP_POS_INF;
                        end else begin
                            result_q <= fp_pack(sx_q, ex_q[EXP_W-1:0], mx_q[MAN_W-1:0]);
                        end
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule
